mem_llsc_unit: RTL and testbench
================================

MEM_LLSC_UNIT -- requirements
Module: mem_llsc_unit

Interface
REQ-001 Parameter ACK_TIMEOUT, default 16: maximum cycles BUSY waits for mem_ack before aborting with bus error.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 op_valid  input  1  EX/MEM presents a memory op this cycle.
REQ-005 op_code  input  4  0 LB, 1 LBU, 2 LH, 3 LHU, 4 LW, 5 SB, 6 SH, 7 SW, 8 LL, 9 SC; others illegal.
REQ-006 op_addr / op_wdata  input  32 / 32  effective address; store data (rt value).
REQ-007 op_wd / op_wreg  input  5 / 1  destination register; write-enable.
REQ-008 flush  input  1  exception/ERET flush: clears LLbit, aborts pending op.
REQ-009 stall_req  output  1  high while an accepted op is outstanding.
REQ-010 mem_req / mem_we  output  1 / 1  bus request; write strobe.
REQ-011 mem_addr / mem_sel / mem_wdata  output  32 / 4 / 32  word address (addr[1:0]=0); byte lanes; lane-replicated store data.
REQ-012 mem_ack / mem_rdata  input  1 / 32  transfer complete; read data valid with ack.
REQ-013 wb_valid / wb_wd / wb_wreg / wb_wdata  output  1 / 5 / 1 / 32  one-cycle result pulse to MEM/WB.
REQ-014 llbit_o  output  1  current LLbit.
REQ-015 err_align / err_bus  output  1 / 1  one-cycle error pulses.

Function
REQ-016 FSM states IDLE, BUSY, RESP; ops accepted only in IDLE when op_valid=1 and flush=0.
REQ-017 IDLE->BUSY on legal aligned op needing bus; mem_req/mem_we/mem_addr/mem_sel/mem_wdata registered, valid first cycle of BUSY.
REQ-018 Bus outputs held stable in BUSY until mem_ack=1; then BUSY->RESP, mem_req drops next cycle.
REQ-019 RESP: wb_valid=1 for exactly one cycle, then IDLE; load-to-wb latency = 2 + wait cycles (3 with ack in first BUSY cycle).
REQ-020 stall_req = 1 in BUSY, and combinationally in IDLE when accepting an op; 0 in RESP.
REQ-021 mem_sel: byte ops one-hot at addr[1:0] (little-endian, 00->0001); half ops 0011/1100 by addr[1]; word/LL/SC 1111.
REQ-022 Loads: LB/LH sign-extend, LBU/LHU zero-extend selected lane; LW/LL full word.
REQ-023 Misalignment (half addr[0]=1; word/LL/SC addr[1:0]!=0): no bus access, err_align pulse next cycle, wb_valid=0, LLbit unchanged.
REQ-024 Illegal op_code: no bus access, no wb, no error, treated as NOP.
REQ-025 LL: word read; LLbit set to 1 in the cycle the RESP result is issued.
REQ-026 SC with LLbit=1: word write of op_wdata; on ack result wb_wdata=1, LLbit cleared.
REQ-027 SC with LLbit=0: no bus access; IDLE->RESP directly, wb_wdata=0, wb_wreg=op_wreg.
REQ-028 Plain stores: no wb (wb_valid=0 in RESP), LLbit unchanged; plain loads leave LLbit unchanged.
REQ-029 Wait counter counts BUSY cycles; at ACK_TIMEOUT without ack: drop mem_req, err_bus pulse, no wb, LLbit cleared, to IDLE.
REQ-030 flush in BUSY/RESP: drop mem_req and wb_valid next cycle, return IDLE, LLbit cleared; a write already acked stays committed.
REQ-031 flush and LL completion same cycle: flush wins, LLbit=0.
REQ-032 mem_ack outside BUSY ignored.

Reset
REQ-033 rst=0 forces IDLE, LLbit=0, counter=0, all outputs 0 immediately, independent of clk.
REQ-034 rst asserted mid-BUSY aborts transfer without wb or error; first accept possible on first edge after release.

Verification
REQ-035 LW 0x0 with mem word 0x00001234, ack 1st BUSY cycle -> wb_valid 3 cycles after accept, wb_wdata 0x00001234.
REQ-036 LL 0x0 (0x1234), SC 0x0 rt=0x5678 -> bus write sel 1111 data 0x5678, wb_wdata 1, llbit_o 0; second SC -> no mem_req, wb_wdata 0.
REQ-037 LB addr 0x3, word 0x80FF0000 -> sel 1000, wb_wdata 0xFFFFFF80; LBU -> 0x00000080; SH addr 0x2 -> sel 1100.
REQ-038 LW addr 0x2 -> err_align pulse, mem_req never asserted, no wb.
REQ-039 LL, then ack withheld 16 cycles on next LW -> err_bus pulse, llbit_o 0, stall_req 0 next cycle.
REQ-040 LL done, flush pulse, SC -> wb_wdata 0 and no bus write; rst=0 mid-BUSY -> mem_req 0 immediately.

Source files
------------

// File: rtl/mem_llsc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : mem_llsc_unit
// Description : MEM-stage load/store unit with LL/SC link bit, single
//               outstanding bus transfer, alignment checks and ack timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_llsc_unit #(
    parameter int ACK_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    input  logic [3:0]  op_code,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    input  logic [4:0]  op_wd,
    input  logic        op_wreg,
    input  logic        flush,
    output logic        stall_req,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_sel,
    output logic [31:0] mem_wdata,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        wb_valid,
    output logic [4:0]  wb_wd,
    output logic        wb_wreg,
    output logic [31:0] wb_wdata,
    output logic        llbit_o,
    output logic        err_align,
    output logic        err_bus
);

    localparam int         CW         = (ACK_TIMEOUT > 1) ? $clog2(ACK_TIMEOUT) : 1;
    localparam logic [CW-1:0] C_CNT_LAST = CW'(ACK_TIMEOUT - 1);
    localparam logic [3:0] C_OP_LB  = 4'd0;
    localparam logic [3:0] C_OP_LBU = 4'd1;
    localparam logic [3:0] C_OP_LH  = 4'd2;
    localparam logic [3:0] C_OP_LHU = 4'd3;
    localparam logic [3:0] C_OP_LW  = 4'd4;
    localparam logic [3:0] C_OP_SB  = 4'd5;
    localparam logic [3:0] C_OP_SH  = 4'd6;
    localparam logic [3:0] C_OP_SW  = 4'd7;
    localparam logic [3:0] C_OP_LL  = 4'd8;
    localparam logic [3:0] C_OP_SC  = 4'd9;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q;
    logic          llbit_q;
    logic [3:0]    op_q;
    logic [1:0]    lane_q;
    logic [4:0]    wd_q;
    logic          wreg_q;
    logic          sc_ok_q;
    logic [31:0]   rdata_q;
    logic          mem_req_q, mem_we_q;
    logic [31:0]   mem_addr_q, mem_wdata_q;
    logic [3:0]    mem_sel_q;
    logic          wb_valid_q, wb_wreg_q;
    logic [4:0]    wb_wd_q;
    logic [31:0]   wb_wdata_q;
    logic          err_align_q, err_bus_q;

    logic          w_accept, w_legal, w_misal, w_go, w_sc_fail, w_to_busy;
    logic          w_is_byte, w_is_half, w_is_store, w_is_sc;
    logic [3:0]    w_sel;
    logic [31:0]   w_store_data;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic [31:0]   w_result;
    logic          w_resp_wb;

    // Decode the presented op: size class, alignment, lane select, store data
    always_comb begin
        w_is_byte    = (op_code == C_OP_LB) || (op_code == C_OP_LBU) || (op_code == C_OP_SB);
        w_is_half    = (op_code == C_OP_LH) || (op_code == C_OP_LHU) || (op_code == C_OP_SH);
        w_is_store   = (op_code == C_OP_SB) || (op_code == C_OP_SH) || (op_code == C_OP_SW);
        w_is_sc      = (op_code == C_OP_SC);
        w_legal      = (op_code <= C_OP_SC);
        w_misal      = w_is_half ? op_addr[0] : (!w_is_byte && (op_addr[1:0] != 2'b00));
        w_sel        = 4'b1111;
        w_store_data = op_wdata;
        if (w_is_byte) begin
            w_sel        = 4'b0001 << op_addr[1:0];
            w_store_data = {4{op_wdata[7:0]}};
        end else if (w_is_half) begin
            w_sel        = op_addr[1] ? 4'b1100 : 4'b0011;
            w_store_data = {2{op_wdata[15:0]}};
        end
    end

    assign w_accept  = (state_q == S_IDLE) && op_valid && !flush;
    assign w_go      = w_accept && w_legal && !w_misal;
    // An SC without a live link completes locally with result 0
    assign w_sc_fail = w_go && w_is_sc && !llbit_q;
    assign w_to_busy = w_go && !w_sc_fail;

    // Extract and extend the addressed lane of the captured read word
    always_comb begin
        w_byte    = rdata_q[{lane_q, 3'b000} +: 8];
        w_half    = lane_q[1] ? rdata_q[31:16] : rdata_q[15:0];
        w_result  = rdata_q;
        w_resp_wb = (op_q <= C_OP_LW) || (op_q == C_OP_LL) || (op_q == C_OP_SC);
        case (op_q)
            C_OP_LB:  w_result = {{24{w_byte[7]}}, w_byte};
            C_OP_LBU: w_result = {24'd0, w_byte};
            C_OP_LH:  w_result = {{16{w_half[15]}}, w_half};
            C_OP_LHU: w_result = {16'd0, w_half};
            C_OP_SC:  w_result = {31'd0, sc_ok_q};
            default:  w_result = rdata_q;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= S_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic; flush and timeout both return to IDLE
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: begin
                if (w_to_busy)      state_d = S_BUSY;
                else if (w_sc_fail) state_d = S_RESP;
            end
            S_BUSY: begin
                if (flush)                   state_d = S_IDLE;
                else if (mem_ack)            state_d = S_RESP;
                else if (cnt_q == C_CNT_LAST) state_d = S_IDLE;
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Bus, op context, result and error registers; LLbit tracking
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q       <= '0;
            llbit_q     <= 1'b0;
            op_q        <= 4'd0;
            lane_q      <= 2'd0;
            wd_q        <= 5'd0;
            wreg_q      <= 1'b0;
            sc_ok_q     <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_sel_q   <= 4'd0;
            mem_wdata_q <= 32'd0;
            wb_valid_q  <= 1'b0;
            wb_wd_q     <= 5'd0;
            wb_wreg_q   <= 1'b0;
            wb_wdata_q  <= 32'd0;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
        end else begin
            wb_valid_q  <= 1'b0;
            err_align_q <= 1'b0;
            err_bus_q   <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    err_align_q <= w_accept && w_legal && w_misal;
                    if (w_go) begin
                        op_q    <= op_code;
                        lane_q  <= op_addr[1:0];
                        wd_q    <= op_wd;
                        wreg_q  <= op_wreg;
                        sc_ok_q <= 1'b0;
                        cnt_q   <= '0;
                    end
                    if (w_to_busy) begin
                        mem_req_q   <= 1'b1;
                        mem_we_q    <= w_is_store || w_is_sc;
                        mem_addr_q  <= {op_addr[31:2], 2'b00};
                        mem_sel_q   <= w_sel;
                        mem_wdata_q <= w_store_data;
                    end
                end
                S_BUSY: begin
                    if (flush) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                    end else if (mem_ack) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        rdata_q   <= mem_rdata;
                        if (op_q == C_OP_SC) begin
                            sc_ok_q <= 1'b1;
                            llbit_q <= 1'b0;
                        end
                    end else if (cnt_q == C_CNT_LAST) begin
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        err_bus_q <= 1'b1;
                        llbit_q   <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_RESP: begin
                    if (!flush) begin
                        wb_valid_q <= w_resp_wb;
                        wb_wd_q    <= wd_q;
                        wb_wreg_q  <= wreg_q;
                        wb_wdata_q <= w_result;
                        if (op_q == C_OP_LL) llbit_q <= 1'b1;
                    end
                end
                default: ;
            endcase
            // Flush always kills the link, overriding an LL completing now
            if (flush) llbit_q <= 1'b0;
        end
    end

    assign stall_req = rst && ((state_q == S_BUSY) || ((state_q == S_IDLE) && (w_to_busy || w_sc_fail)));
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_sel   = mem_sel_q;
    assign mem_wdata = mem_wdata_q;
    assign wb_valid  = wb_valid_q;
    assign wb_wd     = wb_wd_q;
    assign wb_wreg   = wb_wreg_q;
    assign wb_wdata  = wb_wdata_q;
    assign llbit_o   = llbit_q;
    assign err_align = err_align_q;
    assign err_bus   = err_bus_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_llsc_unit.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_mem_llsc_unit
// Description : Directed, table-driven bench for mem_llsc_unit with a
//               bus responder and hand sequences for LL/SC, timeout,
//               flush and reset corner cases.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_llsc_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        op_valid = 1'b0;
    logic [3:0]  op_code = 4'd0;
    logic [31:0] op_addr = 32'd0;
    logic [31:0] op_wdata = 32'd0;
    logic [4:0]  op_wd = 5'd0;
    logic        op_wreg = 1'b0;
    logic        flush = 1'b0;
    logic        stall_req;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_sel;
    logic        mem_ack = 1'b0;
    logic [31:0] mem_rdata = 32'd0;
    logic        wb_valid, wb_wreg;
    logic [4:0]  wb_wd;
    logic [31:0] wb_wdata;
    logic        llbit_o, err_align, err_bus;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    mem_llsc_unit #(.ACK_TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .op_valid(op_valid), .op_code(op_code), .op_addr(op_addr), .op_wdata(op_wdata),
        .op_wd(op_wd), .op_wreg(op_wreg), .flush(flush), .stall_req(stall_req),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_sel(mem_sel),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
        .wb_valid(wb_valid), .wb_wd(wb_wd), .wb_wreg(wb_wreg), .wb_wdata(wb_wdata),
        .llbit_o(llbit_o), .err_align(err_align), .err_bus(err_bus)
    );

    typedef struct {
        logic        req;
        logic [3:0]  sel;
        logic        we;
        logic [31:0] bwd;
        logic [31:0] baddr;
        int          busy;
        logic        wb;
        logic [31:0] wbd;
        logic [4:0]  wwd;
        int          lat;
        logic        ea;
        logic        eb;
        logic        stall0;
        logic        stall_eb;
    } obs_t;

    typedef struct {
        logic [3:0]  code;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        logic        exp_req;
        logic [3:0]  exp_sel;
        logic        exp_we;
        logic [31:0] exp_bwd;
        logic        exp_wb;
        logic [31:0] exp_wbd;
        logic        exp_ea;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issues one op (entered just after a clock edge) and watches 40 cycles.
    // ack_wait: BUSY cycles without ack before ack (-1 = never).
    // flush_cyc: cycle after accept in which flush is pulsed (-1 = never).
    task automatic do_op(input logic [3:0] code, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [31:0] mword,
                         input int ack_wait, input int flush_cyc, output obs_t o);
        int busy;
        busy = 0;
        o = '{default: 0};
        op_valid = 1'b1; op_code = code; op_addr = addr; op_wdata = wdata;
        op_wd = 5'd9; op_wreg = 1'b1;
        #1 o.stall0 = stall_req;
        @(posedge clk); #1;
        op_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            flush = (cyc == flush_cyc);
            if (mem_req) begin
                if (!o.req) begin
                    o.sel = mem_sel; o.we = mem_we; o.bwd = mem_wdata; o.baddr = mem_addr;
                end
                o.req = 1'b1;
                busy++;
                o.busy = busy;
                if (ack_wait >= 0 && busy > ack_wait) begin
                    mem_ack = 1'b1; mem_rdata = mword;
                end
            end
            if (wb_valid && !o.wb) begin
                o.wb = 1'b1; o.wbd = wb_wdata; o.wwd = wb_wd; o.lat = cyc;
            end
            if (err_align) o.ea = 1'b1;
            if (err_bus) begin
                o.eb = 1'b1; o.stall_eb = stall_req;
            end
            @(posedge clk); #1;
            mem_ack = 1'b0; mem_rdata = 32'd0; flush = 1'b0;
        end
    endtask

    vec_t vecs[13];
    obs_t o;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        //               code   addr        wdata         mem word      req  sel    we   bus wdata     wb   wb data       ea
        vecs[0]  = '{4'd4, 32'h0, 32'h0,        32'h00001234, 1'b1, 4'hF, 1'b0, 32'h0,        1'b1, 32'h00001234, 1'b0};
        vecs[1]  = '{4'd0, 32'h3, 32'h0,        32'h80FF0000, 1'b1, 4'h8, 1'b0, 32'h0,        1'b1, 32'hFFFFFF80, 1'b0};
        vecs[2]  = '{4'd1, 32'h3, 32'h0,        32'h80FF0000, 1'b1, 4'h8, 1'b0, 32'h0,        1'b1, 32'h00000080, 1'b0};
        vecs[3]  = '{4'd6, 32'h2, 32'h0000ABCD, 32'h0,        1'b1, 4'hC, 1'b1, 32'hABCDABCD, 1'b0, 32'h0,        1'b0};
        vecs[4]  = '{4'd2, 32'h2, 32'h0,        32'h80FF0000, 1'b1, 4'hC, 1'b0, 32'h0,        1'b1, 32'hFFFF80FF, 1'b0};
        vecs[5]  = '{4'd3, 32'h0, 32'h0,        32'h1234F00D, 1'b1, 4'h3, 1'b0, 32'h0,        1'b1, 32'h0000F00D, 1'b0};
        vecs[6]  = '{4'd5, 32'h1, 32'h000000A5, 32'h0,        1'b1, 4'h2, 1'b1, 32'hA5A5A5A5, 1'b0, 32'h0,        1'b0};
        vecs[7]  = '{4'd4, 32'h2, 32'h0,        32'h0,        1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[8]  = '{4'd2, 32'h1, 32'h0,        32'h0,        1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b1};
        vecs[9]  = '{4'd11, 32'h0, 32'h0,       32'h0,        1'b0, 4'h0, 1'b0, 32'h0,        1'b0, 32'h0,        1'b0};
        vecs[10] = '{4'd7, 32'h8, 32'hDEADBEEF, 32'h0,        1'b1, 4'hF, 1'b1, 32'hDEADBEEF, 1'b0, 32'h0,        1'b0};
        vecs[11] = '{4'd0, 32'h1, 32'h0,        32'h00007F00, 1'b1, 4'h2, 1'b0, 32'h0,        1'b1, 32'h0000007F, 1'b0};
        vecs[12] = '{4'd9, 32'h0, 32'h11111111, 32'h0,        1'b0, 4'h0, 1'b0, 32'h0,        1'b1, 32'h00000000, 1'b0};

        // Asynchronous reset: outputs low before any clock edge acts
        rst = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_mem_req",  {31'd0, mem_req},  32'd0);
        chk("rst_wb_valid", {31'd0, wb_valid}, 32'd0);
        chk("rst_llbit",    {31'd0, llbit_o},  32'd0);
        chk("rst_errs",     {30'd0, err_align, err_bus}, 32'd0);
        chk("rst_stall",    {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;

        // Table-driven single-op vectors, ack in first BUSY cycle
        for (int i = 0; i < 13; i++) begin
            do_op(vecs[i].code, vecs[i].addr, vecs[i].wdata, vecs[i].mword, 0, -1, o);
            chk($sformatf("v%0d_req", i), {31'd0, o.req}, {31'd0, vecs[i].exp_req});
            if (vecs[i].exp_req) begin
                chk($sformatf("v%0d_sel", i),   {28'd0, o.sel}, {28'd0, vecs[i].exp_sel});
                chk($sformatf("v%0d_we", i),    {31'd0, o.we},  {31'd0, vecs[i].exp_we});
                chk($sformatf("v%0d_addr", i),  o.baddr, {vecs[i].addr[31:2], 2'b00});
                if (vecs[i].exp_we) chk($sformatf("v%0d_bwd", i), o.bwd, vecs[i].exp_bwd);
            end
            chk($sformatf("v%0d_wb", i), {31'd0, o.wb}, {31'd0, vecs[i].exp_wb});
            if (vecs[i].exp_wb) chk($sformatf("v%0d_wbd", i), o.wbd, vecs[i].exp_wbd);
            chk($sformatf("v%0d_ea", i),    {31'd0, o.ea}, {31'd0, vecs[i].exp_ea});
            chk($sformatf("v%0d_eb", i),    {31'd0, o.eb}, 32'd0);
            chk($sformatf("v%0d_llbit", i), {31'd0, llbit_o}, 32'd0);
        end

        // Load latency, stall on accept, destination passthrough
        do_op(4'd4, 32'h0, 32'h0, 32'h00001234, 0, -1, o);
        chk("lw_latency", o.lat, 32'd3);
        chk("lw_stall_accept", {31'd0, o.stall0}, 32'd1);
        chk("lw_wb_wd", {27'd0, o.wwd}, 32'd9);
        do_op(4'd4, 32'h4, 32'h0, 32'h00000055, 2, -1, o);
        chk("lw_wait_latency", o.lat, 32'd5);
        chk("lw_wait_data", o.wbd, 32'h00000055);

        // LL / SC success / SC failure
        do_op(4'd8, 32'h0, 32'h0, 32'h00001234, 0, -1, o);
        chk("ll_wbd", o.wbd, 32'h00001234);
        chk("ll_llbit", {31'd0, llbit_o}, 32'd1);
        do_op(4'd9, 32'h0, 32'h00005678, 32'h0, 0, -1, o);
        chk("sc1_req", {31'd0, o.req}, 32'd1);
        chk("sc1_we", {31'd0, o.we}, 32'd1);
        chk("sc1_sel", {28'd0, o.sel}, 32'hF);
        chk("sc1_bwd", o.bwd, 32'h00005678);
        chk("sc1_wbd", o.wbd, 32'd1);
        chk("sc1_llbit", {31'd0, llbit_o}, 32'd0);
        do_op(4'd9, 32'h0, 32'h00005678, 32'h0, 0, -1, o);
        chk("sc2_req", {31'd0, o.req}, 32'd0);
        chk("sc2_wb", {31'd0, o.wb}, 32'd1);
        chk("sc2_wbd", o.wbd, 32'd0);

        // Ack timeout after LL
        do_op(4'd8, 32'h0, 32'h0, 32'h00001234, 0, -1, o);
        chk("to_ll_llbit", {31'd0, llbit_o}, 32'd1);
        do_op(4'd4, 32'h4, 32'h0, 32'h0, -1, -1, o);
        chk("to_err_bus", {31'd0, o.eb}, 32'd1);
        chk("to_busy_cycles", o.busy, 32'd16);
        chk("to_stall", {31'd0, o.stall_eb}, 32'd0);
        chk("to_wb", {31'd0, o.wb}, 32'd0);
        chk("to_llbit", {31'd0, llbit_o}, 32'd0);

        // LL, flush in IDLE, then SC fails locally
        do_op(4'd8, 32'h0, 32'h0, 32'h00001234, 0, -1, o);
        flush = 1'b1;
        @(posedge clk); #1 flush = 1'b0;
        chk("fl_llbit", {31'd0, llbit_o}, 32'd0);
        do_op(4'd9, 32'h0, 32'h00005678, 32'h0, 0, -1, o);
        chk("fl_sc_req", {31'd0, o.req}, 32'd0);
        chk("fl_sc_wbd", o.wbd, 32'd0);

        // Flush during BUSY aborts the load
        do_op(4'd4, 32'h0, 32'h0, 32'h0, -1, 3, o);
        chk("flb_busy", o.busy, 32'd3);
        chk("flb_wb", {31'd0, o.wb}, 32'd0);
        chk("flb_eb", {31'd0, o.eb}, 32'd0);

        // Flush coinciding with LL completion: no result, link stays clear
        do_op(4'd8, 32'h0, 32'h0, 32'h00001234, 0, 2, o);
        chk("flr_wb", {31'd0, o.wb}, 32'd0);
        chk("flr_llbit", {31'd0, llbit_o}, 32'd0);

        // Stray ack while idle is ignored
        mem_ack = 1'b1; mem_rdata = 32'hFFFFFFFF;
        @(posedge clk); @(posedge clk); #1;
        mem_ack = 1'b0; mem_rdata = 32'd0;
        @(posedge clk); #1;
        chk("idle_ack_wb", {31'd0, wb_valid}, 32'd0);
        chk("idle_ack_req", {31'd0, mem_req}, 32'd0);

        // Reset in the middle of a transfer, then accept right after release
        op_valid = 1'b1; op_code = 4'd4; op_addr = 32'h0;
        @(posedge clk); #1 op_valid = 1'b0;
        chk("rb_req_before", {31'd0, mem_req}, 32'd1);
        rst = 1'b0;
        #1;
        chk("rb_req_after", {31'd0, mem_req}, 32'd0);
        chk("rb_stall_after", {31'd0, stall_req}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b1;
        op_valid = 1'b1; op_code = 4'd4; op_addr = 32'h10;
        @(posedge clk); #1 op_valid = 1'b0;
        chk("rb_accept", {31'd0, mem_req}, 32'd1);
        chk("rb_addr", mem_addr, 32'h10);
        mem_ack = 1'b1; mem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1 mem_ack = 1'b0; mem_rdata = 32'd0;
        @(posedge clk); #1;
        chk("rb_wb", {31'd0, wb_valid}, 32'd1);
        chk("rb_wbd", wb_wdata, 32'hCAFEF00D);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
